// File: rtl/param_fifo_buffer.sv
// Parametrised synchronous FIFO with watermarks, occupancy, sticky error flags
// and an optional first-word-fall-through read port.
module param_fifo_buffer #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1,
    parameter int SHOW_AHEAD = 0
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         EN,
    input  logic                         CLR,
    input  logic                         WR,
    input  logic [WIDTH-1:0]             dataIn,
    input  logic                         RD,
    output logic [WIDTH-1:0]             dataOut,
    output logic                         VALID,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         ALMOST_EMPTY,
    output logic                         ALMOST_FULL,
    output logic [$clog2(DEPTH+1)-1:0]   COUNT,
    output logic                         OVERFLOW,
    output logic                         UNDERFLOW
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rptr;
    logic [PW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_empty;
    logic             r_full;
    logic             r_ae;
    logic             r_af;
    logic             r_ovf;
    logic             r_udf;

    logic             w_rd_ok;
    logic             w_wr_ok;
    logic [CW-1:0]    w_cnt_nxt;
    logic [PW-1:0]    w_rptr_nxt;
    logic [PW-1:0]    w_wptr_nxt;

    // A write into a full FIFO is legal only when a pop frees the slot.
    assign w_rd_ok    = RD & ~r_empty;
    assign w_wr_ok    = WR & (~r_full | RD);
    assign w_cnt_nxt  = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
    assign w_rptr_nxt = (r_rptr == PW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
    assign w_wptr_nxt = (r_wptr == PW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;

    always_ff @(posedge Clk) begin
        if (EN && !CLR && w_wr_ok)
            r_mem[r_wptr] <= dataIn;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
            r_ae    <= 1'b1;
            r_af    <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (EN) begin
            if (CLR) begin
                r_rptr  <= '0;
                r_wptr  <= '0;
                r_count <= '0;
                r_valid <= 1'b0;
                r_empty <= 1'b1;
                r_full  <= 1'b0;
                r_ae    <= 1'b1;
                r_af    <= 1'b0;
                r_ovf   <= 1'b0;
                r_udf   <= 1'b0;
            end else begin
                if (w_rd_ok) begin
                    r_rptr <= w_rptr_nxt;
                    r_dout <= r_mem[r_rptr];
                end
                if (w_wr_ok)
                    r_wptr <= w_wptr_nxt;
                r_count <= w_cnt_nxt;
                r_valid <= w_rd_ok;
                r_empty <= (w_cnt_nxt == '0);
                r_full  <= (w_cnt_nxt == CW'(DEPTH));
                r_ae    <= (w_cnt_nxt <= CW'(AE_LEVEL));
                r_af    <= (w_cnt_nxt >= CW'(AF_LEVEL));
                r_ovf   <= r_ovf | (WR & ~w_wr_ok);
                r_udf   <= r_udf | (RD & r_empty);
            end
        end
    end

    // Fall-through mode exposes the head word directly; zero while empty.
    assign dataOut      = (SHOW_AHEAD != 0) ? (r_empty ? '0 : r_mem[r_rptr]) : r_dout;
    assign VALID        = (SHOW_AHEAD != 0) ? ~r_empty : r_valid;
    assign EMPTY        = r_empty;
    assign FULL         = r_full;
    assign ALMOST_EMPTY = r_ae;
    assign ALMOST_FULL  = r_af;
    assign COUNT        = r_count;
    assign OVERFLOW     = r_ovf;
    assign UNDERFLOW    = r_udf;

endmodule

// File: tb/tb_param_fifo_buffer.sv
// Bench for param_fifo_buffer: three configurations driven in lock-step,
// each checked every cycle against a queue-based reference model.
module tb_param_fifo_buffer;

    localparam int NI = 3;
    localparam int D   [NI] = '{4, 5, 4};
    localparam int AFL [NI] = '{3, 4, 3};
    localparam int AEL [NI] = '{1, 2, 1};
    localparam int SA  [NI] = '{0, 0, 1};

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        wr;
    logic        rd;
    logic [15:0] din;

    logic [15:0] dout [NI];
    logic        valid [NI];
    logic        empty [NI];
    logic        full  [NI];
    logic        ae    [NI];
    logic        af    [NI];
    logic [2:0]  cnt   [NI];
    logic        ovf   [NI];
    logic        udf   [NI];

    int n_tests = 0;
    int n_fail  = 0;

    param_fifo_buffer #(.WIDTH(16), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .SHOW_AHEAD(0)) u0 (
        .Clk(clk), .Rst_n(rst_n), .EN(en), .CLR(clr), .WR(wr), .dataIn(din), .RD(rd),
        .dataOut(dout[0]), .VALID(valid[0]), .EMPTY(empty[0]), .FULL(full[0]),
        .ALMOST_EMPTY(ae[0]), .ALMOST_FULL(af[0]), .COUNT(cnt[0]),
        .OVERFLOW(ovf[0]), .UNDERFLOW(udf[0]));

    param_fifo_buffer #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(2), .SHOW_AHEAD(0)) u1 (
        .Clk(clk), .Rst_n(rst_n), .EN(en), .CLR(clr), .WR(wr), .dataIn(din), .RD(rd),
        .dataOut(dout[1]), .VALID(valid[1]), .EMPTY(empty[1]), .FULL(full[1]),
        .ALMOST_EMPTY(ae[1]), .ALMOST_FULL(af[1]), .COUNT(cnt[1]),
        .OVERFLOW(ovf[1]), .UNDERFLOW(udf[1]));

    param_fifo_buffer #(.WIDTH(16), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .SHOW_AHEAD(1)) u2 (
        .Clk(clk), .Rst_n(rst_n), .EN(en), .CLR(clr), .WR(wr), .dataIn(din), .RD(rd),
        .dataOut(dout[2]), .VALID(valid[2]), .EMPTY(empty[2]), .FULL(full[2]),
        .ALMOST_EMPTY(ae[2]), .ALMOST_FULL(af[2]), .COUNT(cnt[2]),
        .OVERFLOW(ovf[2]), .UNDERFLOW(udf[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s u%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endfunction

    // Reference model: a plain queue per instance plus sticky bits.
    logic [15:0] mq [NI][$];
    logic        movf  [NI];
    logic        mudf  [NI];
    logic [15:0] mdout [NI];
    logic        mvalid[NI];

    always @(posedge clk or negedge rst_n) begin
        int  sz;
        logic rok;
        logic wok;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                mq[k].delete();
                movf[k]   = 1'b0;
                mudf[k]   = 1'b0;
                mdout[k]  = '0;
                mvalid[k] = 1'b0;
            end else if (en) begin
                if (clr) begin
                    mq[k].delete();
                    movf[k]   = 1'b0;
                    mudf[k]   = 1'b0;
                    mvalid[k] = 1'b0;
                end else begin
                    sz  = mq[k].size();
                    rok = rd && (sz != 0);
                    wok = wr && ((sz != D[k]) || rd);
                    if (wr && !wok) movf[k] = 1'b1;
                    if (rd && sz == 0) mudf[k] = 1'b1;
                    if (rok) mdout[k] = mq[k].pop_front();
                    if (wok) mq[k].push_back(din);
                    mvalid[k] = rok;
                end
            end
        end
    end

    always @(negedge clk) begin
        int sz;
        for (int k = 0; k < NI; k++) begin
            sz = mq[k].size();
            chk("COUNT", k, 32'(cnt[k]), sz);
            chk("EMPTY", k, 32'(empty[k]), 32'(sz == 0));
            chk("FULL", k, 32'(full[k]), 32'(sz == D[k]));
            chk("ALMOST_EMPTY", k, 32'(ae[k]), 32'(sz <= AEL[k]));
            chk("ALMOST_FULL", k, 32'(af[k]), 32'(sz >= AFL[k]));
            chk("OVERFLOW", k, 32'(ovf[k]), 32'(movf[k]));
            chk("UNDERFLOW", k, 32'(udf[k]), 32'(mudf[k]));
            if (SA[k] != 0) begin
                chk("VALID", k, 32'(valid[k]), 32'(sz != 0));
                if (sz != 0) chk("dataOut", k, 32'(dout[k]), 32'(mq[k][0]));
            end else begin
                chk("VALID", k, 32'(valid[k]), 32'(mvalid[k]));
                chk("dataOut", k, 32'(dout[k]), 32'(mdout[k]));
            end
        end
    end

    task automatic step(input logic w, input logic r, input logic c, input logic [15:0] d);
        wr  = w;
        rd  = r;
        clr = c;
        din = d;
        @(negedge clk);
        wr  = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        en = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst EMPTY", 0, 32'(empty[0]), 1);
        chk("rst AE", 0, 32'(ae[0]), 1);
        chk("rst AF", 0, 32'(af[0]), 0);
        chk("rst dataOut", 0, 32'(dout[0]), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // fill / drain
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 16'hA001 + 16'(i));
            if (i == 2) chk("AF at 3", 0, 32'(af[0]), 1);
        end
        chk("full FULL", 0, 32'(full[0]), 1);
        chk("full COUNT", 0, 32'(cnt[0]), 4);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0);
            chk("drain data", 0, 32'(dout[0]), 32'(16'hA001 + 16'(i)));
            chk("drain VALID", 0, 32'(valid[0]), 1);
            step(0, 0, 0, 0);
            chk("VALID pulse", 0, 32'(valid[0]), 0);
        end
        chk("drain EMPTY", 0, 32'(empty[0]), 1);

        // overflow / underflow / clear
        for (int i = 0; i < 4; i++) step(1, 0, 0, 16'hB001 + 16'(i));
        step(1, 0, 0, 16'hB005);
        chk("ovf flag", 0, 32'(ovf[0]), 1);
        chk("ovf COUNT", 0, 32'(cnt[0]), 4);
        step(0, 1, 0, 0);
        chk("ovf head", 0, 32'(dout[0]), 32'h0000B001);
        step(0, 0, 1, 0);
        chk("clr OVERFLOW", 0, 32'(ovf[0]), 0);
        chk("clr COUNT", 0, 32'(cnt[0]), 0);
        step(0, 1, 0, 0);
        chk("udf flag", 0, 32'(udf[0]), 1);
        chk("udf VALID", 0, 32'(valid[0]), 0);
        step(0, 0, 1, 0);

        // simultaneous read and write
        for (int i = 0; i < 4; i++) step(1, 0, 0, 16'hC001 + 16'(i));
        step(1, 1, 0, 16'hC005);
        chk("rw full COUNT", 0, 32'(cnt[0]), 4);
        chk("rw full OVF", 0, 32'(ovf[0]), 0);
        chk("rw full data", 0, 32'(dout[0]), 32'h0000C001);
        step(0, 0, 1, 0);
        step(1, 1, 0, 16'hD001);
        chk("rw empty UDF", 0, 32'(udf[0]), 1);
        chk("rw empty COUNT", 0, 32'(cnt[0]), 1);
        step(0, 0, 1, 0);

        // fall-through
        step(1, 0, 0, 16'h1234);
        chk("sa data", 2, 32'(dout[2]), 32'h00001234);
        chk("sa VALID", 2, 32'(valid[2]), 1);
        step(0, 1, 0, 0);
        chk("sa pop VALID", 2, 32'(valid[2]), 0);
        chk("sa pop EMPTY", 2, 32'(empty[2]), 1);

        // clock enable hold
        step(1, 0, 0, 16'hE001);
        step(1, 0, 0, 16'hE002);
        en = 1'b0;
        step(1, 1, 1, 16'hE003);
        chk("en0 COUNT", 0, 32'(cnt[0]), 2);
        step(1, 0, 0, 16'hE004);
        chk("en0 COUNT", 0, 32'(cnt[0]), 2);
        step(0, 1, 1, 16'hE005);
        chk("en0 COUNT", 0, 32'(cnt[0]), 2);
        en = 1'b1;

        // wrap on the depth-5 instance
        step(0, 0, 1, 0);
        step(1, 0, 0, 16'hF001);
        step(1, 0, 0, 16'hF002);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 16'hF003 + 16'(i));
        chk("wrap COUNT", 1, 32'(cnt[1]), 2);
        step(0, 1, 0, 0);
        chk("wrap head", 1, 32'(dout[1]), 32'h0000F00D);

        // random traffic with an asynchronous reset mid-burst
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 59) == 0);
            wr  = ($urandom_range(0, 99) < (i < 750 ? 65 : 40));
            rd  = ($urandom_range(0, 99) < (i < 750 ? 40 : 65));
            din = 16'($urandom);
            if (i == 700) begin
                #2 rst_n = 1'b0;
                #1;
                chk("arst COUNT", 0, 32'(cnt[0]), 0);
                chk("arst EMPTY", 0, 32'(empty[0]), 1);
                chk("arst VALID", 0, 32'(valid[0]), 0);
                chk("arst dataOut", 0, 32'(dout[0]), 0);
                chk("arst OVERFLOW", 0, 32'(ovf[0]), 0);
                chk("arst VALID", 2, 32'(valid[2]), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        en = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
